// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory port arbiter.
// Beat counts describe how many single-byte memory cycles each access size needs.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int BEATS_WORD = 4;
    localparam int BEATS_BYTE = 1;

    // Latched command; address and store data are kept beside it because their widths are parameters.
    typedef struct packed {
        logic port;
        logic we;
        logic byte_op;
        logic err;
    } cmd_t;

    function automatic logic [1:0] last_beat(input logic byte_op);
        return byte_op ? 2'(BEATS_BYTE - 1) : 2'(BEATS_WORD - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational, one-hot grant.
// On a tie the port that was not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide memory between fetch (port 0) and load/store (port 1); words move as 4 little-endian beats.
// Done at T+2 for byte ops, T+5 for word ops, T+1 for misaligned errors; requests are held by the requester until done.
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              done0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              byte1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_byte;

    rr_arbiter2 u_arb (
        .req_i        ({req1, req0}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        last_grant_d = last_grant_q;
        req_addr     = addr0;
        req_byte     = 1'b0;
        mem_addr     = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (gnt != 2'b00) begin
                    // Fetch is forced to a word read regardless of the data-port fields.
                    req_addr      = gnt[PORT_DATA] ? addr1 : addr0;
                    req_byte      = gnt[PORT_DATA] & byte1;
                    cmd_d.port    = gnt[PORT_DATA];
                    cmd_d.we      = gnt[PORT_DATA] & we1;
                    cmd_d.byte_op = req_byte;
                    cmd_d.err     = !req_byte && (req_addr[1:0] != 2'b00);
                    addr_d        = req_addr;
                    wdata_d       = gnt[PORT_DATA] ? wdata1 : '0;
                    rbuf_d        = '0;
                    state_d       = cmd_d.err ? DONE : XFER;
                end
            end
            XFER: begin
                mem_addr = addr_q + ADDR_W'(beat_q);
                mem_re   = !cmd_q.we;
                mem_we   = cmd_q.we;
                if (cmd_q.we) begin
                    mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
                end else begin
                    rbuf_d[{beat_q, 3'b000} +: 8] = mem_rdata;
                end
                if (beat_q == last_beat(cmd_q.byte_op)) begin
                    state_d = DONE;
                    // Publish the assembled word now so it is valid alongside the done pulse.
                    if (!cmd_q.we) begin
                        if (cmd_q.port == PORT_DATA) begin
                            rdata1_d = rbuf_d;
                        end else begin
                            rdata0_d = rbuf_d;
                        end
                    end
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            DONE: begin
                last_grant_d = cmd_q.port;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign done0  = (state_q == DONE) && (cmd_q.port == PORT_FETCH);
    assign done1  = (state_q == DONE) && (cmd_q.port == PORT_DATA);
    assign err0   = done0 && cmd_q.err;
    assign err1   = done1 && cmd_q.err;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide memory model and an access log.
module tb_mem_port_arbiter;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic          done0, err0;
    logic [31:0]   rdata0;
    logic          req1 = 1'b0;
    logic          we1 = 1'b0;
    logic          byte1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [31:0]   wdata1 = '0;
    logic          done1, err1;
    logic [31:0]   rdata1;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .addr0     (addr0),
        .done0     (done0),
        .err0      (err0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .byte1     (byte1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .done1     (done1),
        .err1      (err1),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge; preload port used only under reset.
    logic [7:0]    mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [7:0]    pl_dat = '0;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (pl_en)  mem[pl_addr]  <= pl_dat;
    end

    int            acc_cnt = 0;
    int            excl_bad = 0;
    logic [AW-1:0] acc_log [0:255];

    always @(posedge clk) begin
        if (mem_re || mem_we) begin
            acc_log[acc_cnt[7:0]] <= mem_addr;
            acc_cnt <= acc_cnt + 1;
        end
        if (mem_re && mem_we) excl_bad <= excl_bad + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          port;
        logic          we;
        logic          bo;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        int            lat;
        logic          err;
        logic [31:0]   rdata;
        int            beats;
        logic [AW-1:0] first;
        logic [AW-1:0] last;
    } vec_t;

    function automatic vec_t mk(input logic port, input logic we, input logic bo,
                                input logic [AW-1:0] addr, input logic [31:0] wdata,
                                input int lat, input logic err, input logic [31:0] rdata,
                                input int beats, input logic [AW-1:0] first, input logic [AW-1:0] last);
        vec_t v;
        v.port = port; v.we = we; v.bo = bo; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.err = err; v.rdata = rdata; v.beats = beats; v.first = first; v.last = last;
        return v;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int            start;
        int            lat;
        int            beats;
        logic          dn;
        string         tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        if (v.port) begin
            req1 = 1'b1; we1 = v.we; byte1 = v.bo; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; addr0 = v.addr;
        end
        start = acc_cnt;
        lat = 0;
        dn = 1'b0;
        while (!dn && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            dn = v.port ? done1 : done0;
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.lat));
        check({tag, "_err"}, {31'd0, v.port ? err1 : err0}, {31'd0, v.err});
        check({tag, "_rdata"}, v.port ? rdata1 : rdata0, v.rdata);
        beats = acc_cnt - start;
        check({tag, "_beats"}, 32'(beats), 32'(v.beats));
        if (v.beats > 0 && beats > 0) begin
            check({tag, "_first_addr"}, 32'(acc_log[start[7:0]]), 32'(v.first));
            check({tag, "_last_addr"}, 32'(acc_log[8'(acc_cnt - 1)]), 32'(v.last));
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {30'd0, done1, done0}, 32'd0);
    endtask

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ncomp;
        int   ccyc [3];
        logic cwho [3];
        logic seen_done;

        vecs[0]  = mk(1, 1, 0, 18'h00010, 32'hA1B2C3D4, 5, 0, 32'h000000F7, 4, 18'h00010, 18'h00013);
        vecs[1]  = mk(1, 0, 0, 18'h00010, 32'h0,        5, 0, 32'hA1B2C3D4, 4, 18'h00010, 18'h00013);
        vecs[2]  = mk(1, 0, 1, 18'h00025, 32'h0,        2, 0, 32'h000000F7, 1, 18'h00025, 18'h00025);
        vecs[3]  = mk(1, 0, 0, 18'h00006, 32'h0,        1, 1, 32'h000000F7, 0, 18'h0,     18'h0);
        vecs[4]  = mk(0, 0, 0, 18'h00010, 32'h0,        5, 0, 32'hA1B2C3D4, 4, 18'h00010, 18'h00013);
        vecs[5]  = mk(0, 0, 0, 18'h00012, 32'h0,        1, 1, 32'hA1B2C3D4, 0, 18'h0,     18'h0);
        vecs[6]  = mk(1, 1, 1, 18'h3FFFF, 32'h000000EE, 2, 0, 32'h000000F7, 1, 18'h3FFFF, 18'h3FFFF);
        vecs[7]  = mk(0, 0, 0, 18'h3FFFC, 32'h0,        5, 0, 32'hEE332211, 4, 18'h3FFFC, 18'h3FFFF);
        vecs[8]  = mk(1, 1, 1, 18'h00040, 32'hFFFFFF5A, 2, 0, 32'h000000F7, 1, 18'h00040, 18'h00040);
        vecs[9]  = mk(1, 0, 0, 18'h00040, 32'h0,        5, 0, 32'h0000005A, 4, 18'h00040, 18'h00043);
        vecs[10] = mk(1, 0, 1, 18'h00043, 32'h0,        2, 0, 32'h00000000, 1, 18'h00043, 18'h00043);

        // Reset state
        #1;
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_err", {30'd0, err1, err0}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_mem_if", {mem_re, mem_we, 6'd0, mem_wdata, 14'd0}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);

        preload(18'h00025, 8'hF7);
        preload(18'h3FFFC, 8'h11);
        preload(18'h3FFFD, 8'h22);
        preload(18'h3FFFE, 8'h33);
        preload(18'h3FFFF, 8'h44);
        preload(18'h00000, 8'h00);
        for (int a = 0; a < 4; a++) begin
            preload(18'h00010 + 18'(a), 8'h00);
            preload(18'h00040 + 18'(a), 8'h00);
            preload(18'h00080 + 18'(a), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset, both held: grants go 1, 0, 1
        for (int i = 0; i < 3; i++) begin
            ccyc[i] = -1;
            cwho[i] = 1'b0;
        end
        ncomp = 0;
        @(negedge clk);
        req0 = 1'b1; addr0 = 18'h3FFFC;
        req1 = 1'b1; we1 = 1'b0; byte1 = 1'b1; addr1 = 18'h00025;
        for (int cyc = 1; cyc <= 40 && ncomp < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (done0 || done1) begin
                ccyc[ncomp] = cyc;
                cwho[ncomp] = done1;
                ncomp++;
            end
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        check("tie_completions", 32'(ncomp), 32'd3);
        check("tie_first_port", {31'd0, cwho[0]}, 32'd1);
        check("tie_first_cycle", 32'(ccyc[0]), 32'd2);
        check("tie_second_port", {31'd0, cwho[1]}, 32'd0);
        check("tie_second_cycle", 32'(ccyc[1]), 32'd8);
        check("tie_third_port", {31'd0, cwho[2]}, 32'd1);
        check("tie_third_cycle", 32'(ccyc[2]), 32'd11);
        check("tie_rdata0", rdata0, 32'h44332211);
        check("tie_rdata1", rdata1, 32'h000000F7);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) begin
                check("store_byte0", {24'd0, mem[18'h00010]}, 32'hD4);
                check("store_byte1", {24'd0, mem[18'h00011]}, 32'hC3);
                check("store_byte2", {24'd0, mem[18'h00012]}, 32'hB2);
                check("store_byte3", {24'd0, mem[18'h00013]}, 32'hA1);
            end
            if (i == 6) check("no_wrap_write", {24'd0, mem[18'h00000]}, 32'h0);
            if (i == 8) check("byte_store_only", {24'd0, mem[18'h00041]}, 32'h0);
        end

        // Reset during beat 2 of a word store
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; byte1 = 1'b0; addr1 = 18'h00080; wdata1 = 32'h11223344;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_we", {31'd0, mem_we}, 32'd1);
        check("abort_pre_addr", 32'(mem_addr), 32'h82);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_outs", {rdata0 | rdata1}, 32'd0);
        check("abort_done", {28'd0, err1, err0, done1, done0}, 32'd0);
        @(negedge clk);
        req1 = 1'b0;
        seen_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done0 || done1) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        check("abort_mem80", {24'd0, mem[18'h00080]}, 32'h44);
        check("abort_mem81", {24'd0, mem[18'h00081]}, 32'h33);
        check("abort_mem82", {24'd0, mem[18'h00082]}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(1, 0, 0, 18'h00080, 32'h0, 5, 0, 32'h00003344, 4, 18'h00080, 18'h00083), 11);

        check("strobe_exclusive", 32'(excl_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
